// File: rtl/ddr4_cmd_encoder.sv
// DDR4 controller-side command generator: one request at a time, open-page row
// tracking per bank, PRE/ACT/RD/WR with tRP/tRCD spacing and burst-length deselect.
module ddr4_cmd_encoder #(
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int BL        = 8,
  parameter int TRP       = 4,
  parameter int TRCD      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic [ADDRWIDTH-1:0] A,
  output logic                 busy
);

  localparam int MAXT = (TRP > TRCD) ? ((TRP > BL) ? TRP : BL) : ((TRCD > BL) ? TRCD : BL);
  localparam int CW   = $clog2(MAXT + 1);
  localparam int IW   = BGWIDTH + BAWIDTH;
  localparam int NB   = 1 << IW;

  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_PRE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW, S_BURST
  } state_e;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // its fields are latched on that edge and req_ready is low from the next cycle
  // until the request's burst has finished.
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   cke_q;
  logic                   cs_n_q, cs_n_d;
  logic                   act_n_q, act_n_d;
  logic [BGWIDTH-1:0]     bg_q, bg_d;
  logic [BAWIDTH-1:0]     ba_q, ba_d;
  logic [ADDRWIDTH-1:0]   a_q, a_d;
  logic                   lat_wr_q;
  logic [ADDRWIDTH-1:0]   lat_row_q;
  logic [COLWIDTH-1:0]    lat_col_q;
  logic [NB-1:0]          vld_q;
  logic [ADDRWIDTH-1:0]   row_q [NB];

  logic                   accept;
  logic [IW-1:0]          req_idx;
  logic [IW-1:0]          cur_idx;
  logic                   bank_open;
  logic                   row_hit;
  logic                   wr_e;
  logic [ADDRWIDTH-1:0]   row_e;
  logic [COLWIDTH-1:0]    col_e;

  assign req_idx   = {req_bg, req_ba};
  assign cur_idx   = {bg_q, ba_q};
  assign bank_open = vld_q[req_idx];
  assign row_hit   = bank_open && (row_q[req_idx] == req_row);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          accept = 1'b1;
          if (row_hit)        state_d = S_RW;
          else if (bank_open) state_d = S_PRE;
          else                state_d = S_ACT;
        end
      end
      S_PRE: begin
        if (TRP > 1) begin
          state_d = S_PRE_WAIT;
          cnt_d   = CW'(TRP - 2);
        end else begin
          state_d = S_ACT;
        end
      end
      S_PRE_WAIT: begin
        if (cnt_q == '0) state_d = S_ACT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_ACT: begin
        if (TRCD > 1) begin
          state_d = S_ACT_WAIT;
          cnt_d   = CW'(TRCD - 2);
        end else begin
          state_d = S_RW;
        end
      end
      S_ACT_WAIT: begin
        if (cnt_q == '0) state_d = S_RW;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RW: begin
        if (BL > 1) begin
          state_d = S_BURST;
          cnt_d   = CW'(BL - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are registered from the next state, so each command state owns exactly
  // the one cycle its command sits on the bus.
  always_comb begin
    wr_e    = accept ? req_wr  : lat_wr_q;
    row_e   = accept ? req_row : lat_row_q;
    col_e   = accept ? req_col : lat_col_q;
    bg_d    = accept ? req_bg  : bg_q;
    ba_d    = accept ? req_ba  : ba_q;
    cs_n_d  = 1'b1;
    act_n_d = 1'b1;
    a_d     = '0;
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_ACT: begin
        cs_n_d  = 1'b0;
        act_n_d = 1'b0;
        a_d     = row_e;
      end
      S_PRE: begin
        cs_n_d                  = 1'b0;
        a_d[ADDRWIDTH-1 -: 3]   = OP_PRE;
      end
      S_RW: begin
        cs_n_d                  = 1'b0;
        a_d[ADDRWIDTH-1 -: 3]   = wr_e ? OP_WR : OP_RD;
        a_d[COLWIDTH-1:0]       = col_e;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      cke_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      act_n_q   <= 1'b1;
      bg_q      <= '0;
      ba_q      <= '0;
      a_q       <= '0;
      lat_wr_q  <= 1'b0;
      lat_row_q <= '0;
      lat_col_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      cke_q   <= 1'b1;
      cs_n_q  <= cs_n_d;
      act_n_q <= act_n_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      if (accept) begin
        lat_wr_q  <= req_wr;
        lat_row_q <= req_row;
        lat_col_q <= req_col;
      end
    end
  end

  // Open-row table: ACT opens the latched row, PRE closes the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
    end else if (state_q == S_ACT) begin
      vld_q[cur_idx] <= 1'b1;
      row_q[cur_idx] <= lat_row_q;
    end else if (state_q == S_PRE) begin
      vld_q[cur_idx] <= 1'b0;
    end
  end

  assign req_ready = ready_q;
  assign cke       = cke_q;
  assign cs_n      = cs_n_q;
  assign act_n     = act_n_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign A         = a_q;
  assign busy      = (state_q != S_IDLE);

endmodule
